// File: rtl/cfgreg_mc_if.sv
// APB slave bundle for the multi-core configuration register block.
interface cfgreg_mc_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/cfgreg_mc.sv
// Multi-core APB configuration registers: boot vectors, DDR offset, sticky lock, scratch
// registers, and a sequencer that releases core resets one at a time.
module cfgreg_mc #(
    parameter int              NCORE       = 2,
    parameter int              XLEN        = 32,
    parameter int              RST_DLY     = 16,
    parameter logic [XLEN-1:0] BOOTVEC_RST = '0,
    parameter logic [31:0]     DDROFF_RST  = 32'h2000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    cfgreg_mc_if.slave            apb_intf,
    output logic [NCORE*XLEN-1:0] core_bootvec,
    output logic [31:0]           ddr_offset,
    output logic [NCORE-1:0]      core_rstn,
    output logic                  seq_busy
);
    localparam int CW = $clog2(RST_DLY + 1);
    localparam int TW = (NCORE > 1) ? $clog2(NCORE) : 1;

    typedef enum logic [3:0] {
        SEL_NONE, SEL_RSTREQ, SEL_RSTSTAT, SEL_DDROFF, SEL_LOCK,
        SEL_RSV0, SEL_RSV1, SEL_BOOTLO, SEL_BOOTHI
    } sel_t;

    typedef enum logic {IDLE, COUNT} state_t;

    logic [XLEN-1:0]  bootvec [NCORE];
    logic [NCORE-1:0] req;
    logic             lock;
    logic [31:0]      rsv0;
    logic [31:0]      rsv1;
    logic [31:0]      prdata_q;
    logic             err_q;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [TW-1:0]    tgt;
    logic [TW-1:0]    tgt_nx;
    logic [NCORE-1:0] rstn_nx;
    logic [NCORE-1:0] pending;
    logic             tgt_req;

    sel_t             sel;
    logic [11:0]      addr;
    logic [4:0]       idx;
    logic [XLEN-1:0]  cur_bv;
    logic             err;
    logic [31:0]      rdata;
    logic             setup;
    logic             wr_ok;
    logic             unused_addr;

    assign addr        = apb_intf.paddr[11:0];
    assign idx         = addr[7:3];
    assign setup       = apb_intf.psel & ~apb_intf.penable;
    assign wr_ok       = setup & apb_intf.pwrite & ~err;
    assign unused_addr = ^apb_intf.paddr[31:12];

    // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00) begin
            case (addr)
                12'h000: sel = SEL_RSTREQ;
                12'h004: sel = SEL_RSTSTAT;
                12'h008: sel = SEL_DDROFF;
                12'h00C: sel = SEL_LOCK;
                12'h010: sel = SEL_RSV0;
                12'h014: sel = SEL_RSV1;
                default: begin
                    if (addr[11:8] == 4'h1 && 32'(idx) < NCORE) begin
                        if (!addr[2])        sel = SEL_BOOTLO;
                        else if (XLEN == 64) sel = SEL_BOOTHI;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cur_bv = '0;
        for (int i = 0; i < NCORE; i++)
            if (idx == 5'(i)) cur_bv = bootvec[i];
    end

    // Boot vectors and DDR offset are frozen by the lock; everything else ignores it.
    always_comb begin
        err   = 1'b0;
        rdata = '0;
        case (sel)
            SEL_RSTREQ:  rdata = 32'(req);
            SEL_RSTSTAT: begin
                err   = apb_intf.pwrite;
                rdata = 32'(core_rstn);
            end
            SEL_DDROFF:  begin
                err   = apb_intf.pwrite & lock;
                rdata = ddr_offset;
            end
            SEL_LOCK:    rdata = {31'b0, lock};
            SEL_RSV0:    rdata = rsv0;
            SEL_RSV1:    rdata = rsv1;
            SEL_BOOTLO:  begin
                err   = apb_intf.pwrite & lock;
                rdata = cur_bv[31:0];
            end
            SEL_BOOTHI:  begin
                err   = apb_intf.pwrite & lock;
                rdata = cur_bv[XLEN-1 -: 32];
            end
            default:     err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tgt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tgt   <= tgt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tgt_nx   = tgt;
        rstn_nx  = core_rstn;
        pending  = req & ~core_rstn;
        tgt_req  = 1'b0;
        for (int i = 0; i < NCORE; i++)
            if (tgt == TW'(i)) tgt_req = req[i];

        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nx = COUNT;
                    cnt_nx   = CW'(RST_DLY - 1);
                    for (int i = NCORE - 1; i >= 0; i--)
                        if (pending[i]) tgt_nx = TW'(i);
                end
            end
            COUNT: begin
                if (!tgt_req) begin
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    state_nx = IDLE;
                    for (int i = 0; i < NCORE; i++)
                        if (tgt == TW'(i)) rstn_nx[i] = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
        endcase

        // Applied after the release so an assertion on the same edge wins.
        if (wr_ok && sel == SEL_RSTREQ)
            rstn_nx = rstn_nx & apb_intf.pwdata[NCORE-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the boot vector array is reset element by element because its reset value is architectural.
            for (int i = 0; i < NCORE; i++) bootvec[i] <= BOOTVEC_RST;
            req        <= '0;
            core_rstn  <= '0;
            ddr_offset <= DDROFF_RST;
            lock       <= 1'b0;
            rsv0       <= '0;
            rsv1       <= '0;
            prdata_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            core_rstn <= rstn_nx;
            if (setup) begin
                err_q    <= err;
                prdata_q <= (err || apb_intf.pwrite) ? '0 : rdata;
            end
            if (wr_ok) begin
                case (sel)
                    SEL_RSTREQ: req        <= apb_intf.pwdata[NCORE-1:0];
                    SEL_DDROFF: ddr_offset <= apb_intf.pwdata;
                    SEL_LOCK:   lock       <= lock | apb_intf.pwdata[0];
                    SEL_RSV0:   rsv0       <= apb_intf.pwdata;
                    SEL_RSV1:   rsv1       <= apb_intf.pwdata;
                    SEL_BOOTLO: begin
                        for (int i = 0; i < NCORE; i++)
                            if (idx == 5'(i)) bootvec[i][31:0] <= apb_intf.pwdata;
                    end
                    SEL_BOOTHI: begin
                        for (int i = 0; i < NCORE; i++)
                            if (idx == 5'(i)) bootvec[i][XLEN-1 -: 32] <= apb_intf.pwdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NCORE; g++) begin : g_bootvec
        assign core_bootvec[g*XLEN +: XLEN] = bootvec[g];
    end

    assign seq_busy         = (state == COUNT);
    assign apb_intf.pready  = 1'b1;
    assign apb_intf.prdata  = prdata_q;
    assign apb_intf.pslverr = err_q;
endmodule

// File: tb/tb_cfgreg_mc.sv
// Randomized and directed bench for cfgreg_mc; dut0 is tracked cycle by cycle by a
// time-based reference model, dut1 exercises the 64-bit / three-core configuration.
module tb_cfgreg_mc;
    localparam int NC0 = 2, XL0 = 32, DLY0 = 16;
    localparam int NC1 = 3, XL1 = 64, DLY1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cfgreg_mc_if bus0 ();
    cfgreg_mc_if bus1 ();

    logic [NC0*XL0-1:0] bv0;
    logic [31:0]        ddr0;
    logic [NC0-1:0]     rstn0;
    logic               busy0;
    logic [NC1*XL1-1:0] bv1;
    logic [31:0]        ddr1;
    logic [NC1-1:0]     rstn1;
    logic               busy1;

    cfgreg_mc #(.NCORE(NC0), .XLEN(XL0), .RST_DLY(DLY0)) dut0 (
        .clk(clk), .rst(rst), .apb_intf(bus0.slave),
        .core_bootvec(bv0), .ddr_offset(ddr0), .core_rstn(rstn0), .seq_busy(busy0)
    );

    cfgreg_mc #(.NCORE(NC1), .XLEN(XL1), .RST_DLY(DLY1)) dut1 (
        .clk(clk), .rst(rst), .apb_intf(bus1.slave),
        .core_bootvec(bv1), .ddr_offset(ddr1), .core_rstn(rstn1), .seq_busy(busy1)
    );

    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    int          dsel = 0;
    logic [31:0] rdat;
    logic        perr;

    assign bus0.psel    = psel && dsel == 0;
    assign bus0.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus1.psel    = psel && dsel == 1;
    assign bus1.penable = penable;
    assign bus1.pwrite  = pwrite;
    assign bus1.paddr   = paddr;
    assign bus1.pwdata  = pwdata;
    assign rdat = (dsel == 0) ? bus0.prdata : bus1.prdata;
    assign perr = (dsel == 0) ? bus0.pslverr : bus1.pslverr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model of dut0: register file plus a sequencer described by release deadlines.
    logic [NC0-1:0] m_req, m_rstn;
    logic [31:0]    m_ddr, m_rsv0, m_rsv1, m_exp_rd;
    logic [31:0]    m_bv [NC0];
    logic           m_lock, m_exp_err;
    int             m_tgt, m_deadline, m_cyc;

    always @(posedge clk) begin
        logic [NC0-1:0] rstn_nx, pend;
        logic [11:0]    a;
        logic [31:0]    wd, r;
        logic           wr, e;
        int             k;
        if (rst) begin
            m_req = '0; m_rstn = '0; m_ddr = 32'h2000_0000; m_rsv0 = '0; m_rsv1 = '0;
            for (int i = 0; i < NC0; i++) m_bv[i] = '0;
            m_lock = 1'b0; m_exp_rd = '0; m_exp_err = 1'b0; m_tgt = -1; m_deadline = 0;
        end else begin
            rstn_nx = m_rstn;
            pend    = m_req & ~m_rstn;
            if (m_tgt < 0) begin
                if (pend != '0) begin
                    for (int i = NC0 - 1; i >= 0; i--) if (pend[i]) m_tgt = i;
                    m_deadline = m_cyc + DLY0;
                end
            end else if (!m_req[m_tgt]) begin
                m_tgt = -1;
            end else if (m_cyc == m_deadline) begin
                rstn_nx[m_tgt] = 1'b1;
                m_tgt = -1;
            end

            if (bus0.psel && !bus0.penable) begin
                a = bus0.paddr[11:0]; wr = bus0.pwrite; wd = bus0.pwdata;
                e = 1'b0; r = '0;
                if (a[1:0] != 2'b00) e = 1'b1;
                else if (a == 12'h000) begin
                    r = 32'(m_req);
                    if (wr) begin m_req = wd[NC0-1:0]; rstn_nx = rstn_nx & wd[NC0-1:0]; end
                end
                else if (a == 12'h004) begin e = wr; r = 32'(m_rstn); end
                else if (a == 12'h008) begin
                    e = wr && m_lock; r = m_ddr;
                    if (wr && !e) m_ddr = wd;
                end
                else if (a == 12'h00C) begin r = {31'b0, m_lock}; if (wr && wd[0]) m_lock = 1'b1; end
                else if (a == 12'h010) begin r = m_rsv0; if (wr) m_rsv0 = wd; end
                else if (a == 12'h014) begin r = m_rsv1; if (wr) m_rsv1 = wd; end
                else if (a >= 12'h100 && a < 12'h100 + 12'(8 * NC0) && !a[2]) begin
                    k = int'((a - 12'h100) / 12'd8);
                    e = wr && m_lock; r = m_bv[k];
                    if (wr && !e) m_bv[k] = wd;
                end
                else e = 1'b1;
                m_exp_err = e;
                m_exp_rd  = (e || wr) ? 32'h0 : r;
            end
            m_rstn = rstn_nx;
        end
        m_cyc++;
    end

    initial m_cyc = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            check("rstn0", 64'(rstn0), 64'(m_rstn));
            check("busy0", 64'(busy0), 64'(m_tgt >= 0));
            check("ddr0", 64'(ddr0), 64'(m_ddr));
            check("bootvec0", bv0, {m_bv[1], m_bv[0]});
        end
    end

    task automatic apb(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd = rdat; er = perr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_chk(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        apb(d, 1'b1, a, wd, rd, er);
        check({tag, "_err"}, 64'(er), 64'(exp_err));
        if (exp_err) check({tag, "_rd"}, 64'(rd), 64'h0);
    endtask

    task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        apb(d, 1'b0, a, 32'h0, rd, er);
        check({tag, "_err"}, 64'(er), 64'(exp_err));
        check({tag, "_rd"}, 64'(rd), 64'(exp_rd));
    endtask

    task automatic wait_rise(input int d, input int b, input int t0, output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((d == 0) ? rstn0[b] : rstn1[b]) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    logic [11:0] pool [14];

    initial begin
        int          t0, lat;
        logic [31:0] rd, wd, tmp;
        logic [11:0] a;
        logic        wr, er;

        pool = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h100,
                 12'h104, 12'h108, 12'h10C, 12'h110, 12'h018, 12'h002, 12'h000};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;

        check("pready", 64'(bus0.pready), 64'h1);
        check("rst_rstn0", 64'(rstn0), 64'h0);
        rd_chk(0, 32'h008, 32'h2000_0000, 1'b0, "rst_ddr");
        rd_chk(0, 32'h004, 32'h0, 1'b0, "rst_stat");
        rd_chk(0, 32'h100, 32'h0, 1'b0, "rst_bv");

        t0 = cyc;
        wr_chk(0, 32'h000, 32'h3, 1'b0, "req3");
        wait_rise(0, 0, t0, lat);
        check("lat_core0", 64'(lat), 64'(DLY0 + 2));
        wait_rise(0, 1, t0, lat);
        check("lat_core1", 64'(lat), 64'(2 * DLY0 + 3));
        rd_chk(0, 32'h004, 32'h3, 1'b0, "stat_after");

        wr_chk(0, 32'h000, 32'h0, 1'b0, "req_clear");
        check("assert_now", 64'(rstn0), 64'h0);
        wr_chk(0, 32'h000, 32'h1, 1'b0, "abort_req");
        repeat (3) @(negedge clk);
        check("busy_pre_abort", 64'(busy0), 64'h1);
        wr_chk(0, 32'h000, 32'h0, 1'b0, "abort_clr");
        check("busy_post_abort", 64'(busy0), 64'h0);
        repeat (30) @(negedge clk);
        check("abort_no_rel", 64'(rstn0), 64'h0);

        for (int n = 0; n < 250; n++) begin
            a   = pool[$urandom_range(0, 13)];
            tmp = $urandom;
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (a == 12'h00C) wd[0] = ($urandom_range(0, 9) == 0);
            apb(0, wr, {tmp[31:12], a}, wd, rd, er);
            check("rnd_err", 64'(er), 64'(m_exp_err));
            if (!wr || er) check("rnd_rd", 64'(rd), 64'(m_exp_rd));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_chk(0, 32'h018, 32'h0, 1'b1, "err_018");
        wr_chk(0, 32'h018, 32'hFFFF_FFFF, 1'b1, "err_w018");
        rd_chk(0, 32'h110, 32'h0, 1'b1, "err_110");
        rd_chk(0, 32'h104, 32'h0, 1'b1, "err_104");
        rd_chk(0, 32'h002, 32'h0, 1'b1, "err_002");
        wr_chk(0, 32'h004, 32'h3, 1'b1, "err_wstat");
        rd_chk(0, 32'h000, 32'h0, 1'b0, "req_unchanged");

        wr_chk(0, 32'h008, 32'h8000_0000, 1'b0, "ddr_w");
        wr_chk(0, 32'h00C, 32'h1, 1'b0, "lock_w");
        wr_chk(0, 32'h008, 32'h1234_0000, 1'b1, "ddr_locked");
        rd_chk(0, 32'h008, 32'h8000_0000, 1'b0, "ddr_kept");
        wr_chk(0, 32'h100, 32'hCAFE_0000, 1'b1, "bv_locked");
        wr_chk(0, 32'h00C, 32'h0, 1'b0, "lock_w0");
        wr_chk(0, 32'h00C, 32'h1, 1'b0, "lock_w1_again");
        rd_chk(0, 32'h00C, 32'h1, 1'b0, "lock_sticky");
        wr_chk(0, 32'h010, 32'hA5A5_0001, 1'b0, "rsv0_w");
        rd_chk(0, 32'h010, 32'hA5A5_0001, 1'b0, "rsv0_r");
        wr_chk(0, 32'h000, 32'h2, 1'b0, "req_locked_ok");
        rd_chk(0, 32'h000, 32'h2, 1'b0, "req_locked_rd");

        wr_chk(1, 32'h108, 32'hDEAD_BEEF, 1'b0, "x64_lo");
        wr_chk(1, 32'h10C, 32'h0000_0001, 1'b0, "x64_hi");
        check("x64_bootvec1", bv1[127:64], 64'h1_DEAD_BEEF);
        rd_chk(1, 32'h10C, 32'h1, 1'b0, "x64_hi_rd");
        rd_chk(1, 32'h118, 32'h0, 1'b1, "x64_err_118");
        t0 = cyc;
        wr_chk(1, 32'h000, 32'h7, 1'b0, "x64_req7");
        wait_rise(1, 0, t0, lat);
        check("x64_lat0", 64'(lat), 64'(DLY1 + 2));
        wait_rise(1, 1, t0, lat);
        check("x64_lat1", 64'(lat), 64'(2 * DLY1 + 3));
        wait_rise(1, 2, t0, lat);
        check("x64_lat2", 64'(lat), 64'(3 * DLY1 + 4));

        wr_chk(1, 32'h000, 32'h0, 1'b0, "mid_clr");
        wr_chk(1, 32'h000, 32'h1, 1'b0, "mid_req");
        check("mid_busy", 64'(busy1), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_rstn", 64'(rstn1), 64'h0);
        check("mid_busy_off", 64'(busy1), 64'h0);
        check("mid_bootvec", bv1[127:64], 64'h0);
        rd_chk(0, 32'h008, 32'h2000_0000, 1'b0, "mid_ddr0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
